mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator-side load/store controller that drives the data_memory port (address, write_data, memread, memwrite, read_data) on behalf of the MEM pipeline stage.
- Accepts one byte, halfword or word request at a time over a valid/ready handshake.
- Performs sub-word stores as a read-modify-write sequence and sign- or zero-extends sub-word loads.
- Returns a one-cycle response pulse, or flags a misaligned access without touching memory.

Parameters:
- ADDR_W, 32, width of request and memory address.
- DATA_W, 32, width of the data path. Fixed at 32; byte-lane logic assumes 4 lanes.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request (IDLE only).
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  input  1  sign-extend loads. Ignored for stores and word loads.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  store data, right-justified.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  DATA_W  extended load data; 0 for stores and errors.
- resp_misaligned  output  1  qualifies resp_valid; the access was not performed.
- address  output  ADDR_W  to data_memory; word-aligned (req_addr with bits [1:0] forced to 0).
- write_data  output  DATA_W  to data_memory.
- memread  output  1  to data_memory.
- memwrite  output  1  to data_memory.
- read_data  input  DATA_W  from data_memory; combinational read.

Behaviour:
- Reset values: req_ready=0 while rst_n=0, 1 in IDLE afterwards. resp_valid, resp_misaligned, memread, memwrite=0. address, write_data, resp_rdata=0. All memory-side outputs are registered; no combinational path from req_* to memread/memwrite/address/write_data.
- Byte order is big-endian. Byte offset 0 maps to bits [31:24], offset 3 to [7:0]. Halfword offset 0 maps to [31:16], offset 2 to [15:0].
- Misaligned: size 01 with addr[0]=1, size 10 with addr[1:0]!=0, or size 11. Result is IDLE -> RESP with resp_misaligned=1 and resp_rdata=0. memread and memwrite never assert.
- FSM states: IDLE, RD, WR, RESP. A request is accepted on the clk edge where req_valid && req_ready; all req_* fields are latched at that edge.
- Load: IDLE -> RD (memread=1 for exactly one cycle) -> RESP. read_data is captured at the RD->RESP edge, then lane-selected and extended.
- Load latency: accept at edge N; resp_valid high during cycle N+2.
- Store word: IDLE -> WR (memwrite=1 for exactly one cycle, write_data=req_wdata) -> RESP.
- Store byte/half: IDLE -> RD -> WR -> RESP. In WR, write_data is the captured word with the target lane(s) replaced by req_wdata[7:0] or req_wdata[15:0]. resp_valid is high in cycle N+3.
- address is held constant across RD and WR of one request.
- memread and memwrite are never simultaneously 1. Both are 0 in IDLE and RESP.
- RESP lasts one cycle, then returns to IDLE. resp_valid has no backpressure. req_ready=0 in RD, WR and RESP; req_valid is ignored in those states.
- resp_rdata and resp_misaligned are valid only while resp_valid=1 and read 0 otherwise.
- Reset mid-operation: all outputs clear immediately on rst_n falling; state returns to IDLE. A write not yet reaching WR does not occur. A WR cycle cut short leaves the memory word undefined.
- Back-to-back: the next request may be accepted in the IDLE cycle directly following RESP.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> all outputs 0, memread/memwrite never high. Release -> req_ready=1 in the next cycle.
- Word 0x20 preloaded 0x8899AABB; lw 0x20 -> memread=1 with address 0x20 for one cycle at N+1. resp_valid at N+2 with resp_rdata=0x8899AABB, resp_misaligned=0.
- Same word: lb 0x21 -> 0xFFFFFF99. lbu 0x21 -> 0x00000099. lh 0x22 -> 0xFFFFAABB. lhu 0x20 -> 0x00008899.
- sb 0x22 with req_wdata 0x123456CC -> RD cycle, then WR cycle with address 0x20 and write_data 0x8899CCBB, resp_valid at N+3. A following lw 0x20 -> 0x8899CCBB.
- Misaligned: sh 0x21, lw 0x22, and size=11 -> resp_valid at N+1 with resp_misaligned=1 and resp_rdata=0. memread and memwrite stay 0; the memory word is unchanged.
- Reset mid-op: sb 0x24 (word 0x00000024), assert rst_n=0 during RD -> memread drops without waiting for clk, memwrite never asserts. The word still reads 0x00000024 after release.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request/response channel between the MEM stage and the load/store controller.
//
// Handshake: a request transfers on the rising clk edge where req_valid and
// req_ready are both 1; the initiator holds all req_* fields stable while
// req_valid is high. resp_valid is a single-cycle pulse with no backpressure;
// resp_rdata and resp_misaligned are meaningful only while resp_valid is 1.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_misaligned;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store controller for the MEM stage. Byte/halfword/word accesses with
// big-endian lane mapping; sub-word stores are done as read-modify-write.
// Every output is registered, so nothing on the request side reaches the
// memory port combinationally.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_unit_if.slave  req,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    output logic              memread,
    output logic              memwrite,
    input  logic [DATA_W-1:0] read_data,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [1:0]        off_q, off_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              memread_q, memread_d;
    logic              memwrite_q, memwrite_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_mis_q, resp_mis_d;
    logic              req_mis;

    // Picks the addressed lane(s) out of a word and extends to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] size,
                                                input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replaces the addressed lane(s) of the old word with new store data.
    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [15:0] d,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = w;
        if (size == 2'b00) begin
            case (off)
                2'd0:    r[31:24] = d[7:0];
                2'd1:    r[23:16] = d[7:0];
                2'd2:    r[15:8]  = d[7:0];
                default: r[7:0]   = d[7:0];
            endcase
        end else if (off[1]) begin
            r[15:0] = d;
        end else begin
            r[31:16] = d;
        end
        return r;
    endfunction

    // Misalignment is judged on the live request so it can skip memory entirely.
    always_comb begin
        req_mis = 1'b0;
        case (req.req_size)
            2'b01:   req_mis = req.req_addr[0];
            2'b10:   req_mis = (req.req_addr[1:0] != 2'b00);
            2'b11:   req_mis = 1'b1;
            default: req_mis = 1'b0;
        endcase
    end

    // Next-state and registered-output computation for the access sequence.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        address_d    = address_q;
        write_data_d = '0;
        resp_rdata_d = '0;
        resp_mis_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req.req_valid && ready_q) begin
                    write_d  = req.req_write;
                    size_d   = req.req_size;
                    signed_d = req.req_signed;
                    off_d    = req.req_addr[1:0];
                    wdata_d  = req.req_wdata[15:0];
                    if (req_mis) begin
                        state_d    = S_RESP;
                        resp_mis_d = 1'b1;
                    end else begin
                        address_d = {req.req_addr[ADDR_W-1:2], 2'b00};
                        if (req.req_write && req.req_size == 2'b10) begin
                            state_d      = S_WR;
                            write_data_d = req.req_wdata;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
            end
            S_RD: begin
                if (write_q) begin
                    state_d      = S_WR;
                    write_data_d = store_merge(read_data, wdata_q, size_q, off_q);
                end else begin
                    state_d      = S_RESP;
                    resp_rdata_d = load_extend(read_data, size_q, off_q, signed_q);
                end
            end
            S_WR:    state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
        ready_d      = (state_d == S_IDLE);
        memread_d    = (state_d == S_RD);
        memwrite_d   = (state_d == S_WR);
        resp_valid_d = (state_d == S_RESP);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b0;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= '0;
            address_q    <= '0;
            write_data_q <= '0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_mis_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            memread_q    <= memread_d;
            memwrite_q   <= memwrite_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_mis_q   <= resp_mis_d;
        end
    end

    assign req.req_ready       = ready_q;
    assign req.resp_valid      = resp_valid_q;
    assign req.resp_rdata      = resp_rdata_q;
    assign req.resp_misaligned = resp_mis_q;
    assign address             = address_q;
    assign write_data          = write_data_q;
    assign memread             = memread_q;
    assign memwrite            = memwrite_q;
    assign dbg_state           = state_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed byte-lane cases, misaligned cases,
// randomized traffic against a word-array reference model, and reset mid-op.
module tb_mem_access_unit;
    logic        clk;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        memread;
    logic        memwrite;
    logic [31:0] read_data;
    logic [1:0]  dbg_state;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic [32:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) rif ();

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (rif.slave),
        .address    (address),
        .write_data (write_data),
        .memread    (memread),
        .memwrite   (memwrite),
        .read_data  (read_data),
        .dbg_state  (dbg_state)
    );

    // clock / memory block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign read_data = mem[address[7:2]];

    always @(posedge clk) begin
        if (memwrite) mem[address[7:2]] <= write_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model
    function automatic bit model_mis(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
        return (addr % (32'd1 << size)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                               input int off, input bit sgn);
        int          nbytes;
        int          shift;
        logic [31:0] mask;
        logic [31:0] v;
        if (size == 2'd2) return w;
        nbytes = (size == 2'd0) ? 1 : 2;
        shift  = (4 - off - nbytes) * 8;
        mask   = (32'd1 << (nbytes * 8)) - 1;
        v      = (w >> shift) & mask;
        if (sgn && v[nbytes * 8 - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] d,
                                                input logic [1:0] size, input int off);
        int          nbytes;
        int          shift;
        logic [31:0] mask;
        if (size == 2'd2) return d;
        nbytes = (size == 2'd0) ? 1 : 2;
        shift  = (4 - off - nbytes) * 8;
        mask   = (32'd1 << (nbytes * 8)) - 1;
        return (w & ~(mask << shift)) | ((d & mask) << shift);
    endfunction

    // driver: enters and leaves at the negedge of an IDLE cycle
    task automatic do_req(input bit wr, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bit          mis;
        int          lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_wd;
        logic [31:0] rdata;
        int          idx;
        int          rd_cnt;
        int          wr_cnt;
        int          bad_addr;
        int          bad_ready;
        int          both;
        int          got_lat;
        logic [31:0] got_wd;
        logic [32:0] got;
        logic [32:0] exp;
        idx    = int'(addr[7:2]);
        mis    = model_mis(size, addr);
        exp_wd = 32'h0;
        rdata  = 32'h0;
        if (mis) begin
            lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!wr) begin
            lat = 2; exp_rd = 1; exp_wr = 0;
            rdata = model_load(ref_mem[idx], size, int'(addr[1:0]), sgn);
        end else begin
            lat    = (size == 2'd2) ? 2 : 3;
            exp_rd = (size == 2'd2) ? 0 : 1;
            exp_wr = 1;
            exp_wd = model_store(ref_mem[idx], wdata, size, int'(addr[1:0]));
            ref_mem[idx] = exp_wd;
        end
        exp_q.push_back({mis, rdata});

        rif.req_valid  = 1'b1;
        rif.req_write  = wr;
        rif.req_size   = size;
        rif.req_signed = sgn;
        rif.req_addr   = addr;
        rif.req_wdata  = wdata;
        check_eq("req_ready_idle", {31'b0, rif.req_ready}, 32'd1);
        @(posedge clk);
        #1 rif.req_valid = 1'b0;

        rd_cnt = 0; wr_cnt = 0; bad_addr = 0; bad_ready = 0; both = 0;
        got_lat = 0; got_wd = 32'h0; got = 33'h0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (memread)  rd_cnt++;
            if (memwrite) begin
                wr_cnt++;
                got_wd = write_data;
            end
            if (memread && memwrite) both++;
            if ((memread || memwrite) && address !== {addr[31:2], 2'b00}) bad_addr++;
            if (rif.req_ready) bad_ready++;
            if (rif.resp_valid) begin
                got_lat = c;
                got     = {rif.resp_misaligned, rif.resp_rdata};
                break;
            end
        end
        exp = exp_q.pop_front();
        if (got_lat == 0) check_eq("resp_timeout", 32'd0, 32'd1);
        check_eq("latency", got_lat, lat);
        check_eq("resp_misaligned", {31'b0, got[32]}, {31'b0, exp[32]});
        check_eq("resp_rdata", got[31:0], exp[31:0]);
        check_eq("memread_cycles", rd_cnt, exp_rd);
        check_eq("memwrite_cycles", wr_cnt, exp_wr);
        check_eq("rd_wr_overlap", both, 0);
        check_eq("mem_address", bad_addr, 0);
        check_eq("ready_when_busy", bad_ready, 0);
        if (exp_wr != 0) check_eq("write_data", got_wd, exp_wd);
        @(negedge clk);
        check_eq("resp_pulse_width", {31'b0, rif.resp_valid}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[8] = 32'h8899AABB; ref_mem[8] = 32'h8899AABB;
        mem[9] = 32'h00000024; ref_mem[9] = 32'h00000024;

        // reset with a pending request
        rst_n          = 1'b0;
        rif.req_valid  = 1'b1;
        rif.req_write  = 1'b1;
        rif.req_size   = 2'd2;
        rif.req_signed = 1'b0;
        rif.req_addr   = 32'h20;
        rif.req_wdata  = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_ready", {31'b0, rif.req_ready}, 32'd0);
            check_eq("rst_outputs", {28'b0, rif.resp_valid, rif.resp_misaligned, memread, memwrite}, 32'd0);
            check_eq("rst_address", address, 32'd0);
            check_eq("rst_write_data", write_data, 32'd0);
            check_eq("rst_rdata", rif.resp_rdata, 32'd0);
            check_eq("rst_state", {30'b0, dbg_state}, 32'd0);
        end
        rst_n         = 1'b1;
        rif.req_valid = 1'b0;
        @(negedge clk);
        check_eq("ready_after_reset", {31'b0, rif.req_ready}, 32'd1);

        // directed lane cases on word 0x20
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        do_req(1'b0, 2'd0, 1'b1, 32'h21, 32'h0);
        do_req(1'b0, 2'd0, 1'b0, 32'h21, 32'h0);
        do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
        do_req(1'b0, 2'd1, 1'b0, 32'h20, 32'h0);
        do_req(1'b1, 2'd0, 1'b0, 32'h22, 32'h123456CC);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        check_eq("sb_result_word", mem[8], 32'h8899CCBB);
        // misaligned
        do_req(1'b1, 2'd1, 1'b0, 32'h21, 32'hFFFF5555);
        do_req(1'b0, 2'd2, 1'b0, 32'h22, 32'h0);
        do_req(1'b1, 2'd3, 1'b0, 32'h20, 32'h11111111);
        check_eq("mis_word_unchanged", mem[8], 32'h8899CCBB);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << ((sz == 2'd3) ? 0 : sz)) - 1);
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        for (int i = 0; i < 64; i++) begin
            check_eq("mem_vs_model", mem[i], ref_mem[i]);
        end

        // reset during the read phase of a sub-word store
        mem[9] = 32'h00000024; ref_mem[9] = 32'h00000024;
        rif.req_valid  = 1'b1;
        rif.req_write  = 1'b1;
        rif.req_size   = 2'd0;
        rif.req_signed = 1'b0;
        rif.req_addr   = 32'h24;
        rif.req_wdata  = 32'h000000EE;
        @(posedge clk);
        #1 rif.req_valid = 1'b0;
        @(negedge clk);
        check_eq("midop_memread", {31'b0, memread}, 32'd1);
        check_eq("midop_address", address, 32'h24);
        rst_n = 1'b0;
        #1;
        check_eq("midop_rst_memread", {31'b0, memread}, 32'd0);
        check_eq("midop_rst_address", address, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("midop_rst_memwrite", {31'b0, memwrite}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        do_req(1'b0, 2'd2, 1'b0, 32'h24, 32'h0);
        check_eq("midop_word_intact", mem[9], 32'h00000024);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
